// File: rtl/seq_slice_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands SLICE bits per
// clock from the top slice down, with optional early exit and G/E/L cascade inputs.
module seq_slice_comparator #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3,
  parameter int EARLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic             SGN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             G,
  input  logic             E,
  input  logic             L,
  output logic             BUSY,
  output logic             DONE,
  output logic             G_T,
  output logic             E_Q,
  output logic             L_T,
  output logic             state_dbg
);

  // Handshake: START is taken on any rising edge while IDLE (BUSY=0) and is
  // dropped otherwise; DONE is a single-cycle pulse and G_T/E_Q/L_T hold until
  // the next DONE. There is no backpressure on the result side.

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

  typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             gt, lt;
  logic             g_c, e_c, l_c;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_gt, sl_lt;
  logic             gt_nx, lt_nx, eq_nx;
  logic             finish;

  // Current slice compare feeds the finishing edge directly (no extra stage).
  always_comb begin
    a_sl   = a_q[idx*SLICE +: SLICE];
    b_sl   = b_q[idx*SLICE +: SLICE];
    sl_gt  = (a_sl > b_sl);
    sl_lt  = (a_sl < b_sl);
    gt_nx  = gt | (~gt & ~lt & sl_gt);
    lt_nx  = lt | (~gt & ~lt & sl_lt);
    eq_nx  = ~gt_nx & ~lt_nx;
    finish = (idx == '0) || ((EARLY != 0) && (sl_gt || sl_lt));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = CMP;
      CMP:     if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      g_c  <= 1'b0;
      e_c  <= 1'b0;
      l_c  <= 1'b0;
      DONE <= 1'b0;
      G_T  <= 1'b0;
      E_Q  <= 1'b0;
      L_T  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE && START) begin
        // Flipping the sign bit of both operands maps signed order onto unsigned.
        a_q <= {A[WIDTH-1] ^ SGN, A[WIDTH-2:0]};
        b_q <= {B[WIDTH-1] ^ SGN, B[WIDTH-2:0]};
        g_c <= G;
        e_c <= E;
        l_c <= L;
        idx <= IDX_TOP;
        gt  <= 1'b0;
        lt  <= 1'b0;
      end else if (state == CMP) begin
        gt <= gt_nx;
        lt <= lt_nx;
        if (finish) begin
          G_T  <= gt_nx | (eq_nx & g_c);
          E_Q  <= eq_nx & e_c;
          L_T  <= lt_nx | (eq_nx & l_c);
          DONE <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  assign BUSY      = (state == CMP);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Directed plus random bench for seq_slice_comparator with WIDTH=12, SLICE=3,
// covering both the early-exit and constant-time builds side by side.
module tb_seq_slice_comparator;

  localparam int W  = 12;
  localparam int S  = 3;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         early_sel = 1'b1;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         g = 1'b0, e = 1'b0, l = 1'b0;

  logic start_e, start_c;
  logic busy_e, done_e, gt_e, eq_e, lt_e, st_e;
  logic busy_c, done_c, gt_c, eq_c, lt_c, st_c;
  logic busy_m, done_m, st_m;
  logic [2:0] flags_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_n   = 0;

  logic [2:0] exp_q[$];
  int         lat_q[$];

  always #5 clk = ~clk;

  assign start_e = start & early_sel;
  assign start_c = start & ~early_sel;
  assign busy_m  = early_sel ? busy_e : busy_c;
  assign done_m  = early_sel ? done_e : done_c;
  assign st_m    = early_sel ? st_e : st_c;
  assign flags_m = early_sel ? {gt_e, eq_e, lt_e} : {gt_c, eq_c, lt_c};

  seq_slice_comparator #(.WIDTH(W), .SLICE(S), .EARLY(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .START(start_e), .SGN(sgn), .A(a), .B(b),
    .G(g), .E(e), .L(l), .BUSY(busy_e), .DONE(done_e), .G_T(gt_e),
    .E_Q(eq_e), .L_T(lt_e), .state_dbg(st_e)
  );

  seq_slice_comparator #(.WIDTH(W), .SLICE(S), .EARLY(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .START(start_c), .SGN(sgn), .A(a), .B(b),
    .G(g), .E(e), .L(l), .BUSY(busy_c), .DONE(done_c), .G_T(gt_c),
    .E_Q(eq_c), .L_T(lt_c), .state_dbg(st_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: full-width compare plus top-down scan for latency.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic msgn, input logic mg, input logic me,
                                input logic ml, input logic mearly,
                                output logic [2:0] f, output int lat);
    logic mgt, mlt, meq, found;
    mgt = msgn ? ($signed(ma) > $signed(mb)) : (ma > mb);
    mlt = msgn ? ($signed(ma) < $signed(mb)) : (ma < mb);
    meq = !mgt && !mlt;
    f = {mgt | (meq & mg), meq & me, mlt | (meq & ml)};
    lat = NS;
    found = 1'b0;
    if (mearly) begin
      for (int k = NS - 1; k >= 0; k--) begin
        if (!found && (ma[k*S +: S] != mb[k*S +: S])) begin
          lat = NS - k;
          found = 1'b1;
        end
      end
    end
  endfunction

  task automatic set_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tg, input logic te, input logic tl);
    a = ta; b = tb_; sgn = ts; g = tg; e = te; l = tl;
  endtask

  task automatic accept_edge();
    @(posedge clk); #1;
    cyc = 0;
    busy_n = busy_m ? 1 : 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (busy_m) busy_n++;
  endtask

  task automatic wait_done(input string tag, input bit pulse);
    logic [2:0] f;
    int lat;
    while (!done_m && cyc < 30) step();
    check({tag, "_done"}, 32'(done_m), 32'd1);
    f = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "_flags"}, 32'(flags_m), 32'(f));
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_busy"}, 32'(busy_n), 32'(lat));
    if (pulse) begin
      step();
      check({tag, "_pulse"}, 32'(done_m), 32'd0);
      check({tag, "_hold"}, 32'(flags_m), 32'(f));
    end
  endtask

  task automatic run_op(input string tag, input logic te_sel, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic ts, input logic tg,
                        input logic te, input logic tl, input logic [2:0] f, input int lat);
    @(negedge clk);
    early_sel = te_sel;
    set_ops(ta, tb_, ts, tg, te, tl);
    start = 1'b1;
    exp_q.push_back(f);
    lat_q.push_back(lat);
    accept_edge();
    start = 1'b0;
    check({tag, "_busy0"}, 32'(busy_m), 32'd1);
    wait_done(tag, 1'b1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_e", 32'({busy_e, done_e, gt_e, eq_e, lt_e, st_e}), 32'd0);
    check("rst_c", 32'({busy_c, done_c, gt_c, eq_c, lt_c, st_c}), 32'd0);
    rst_n = 1'b1;

    run_op("u_gt",     1'b1, 12'h800, 12'h7FF, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1);
    run_op("s_lt",     1'b1, 12'h800, 12'h7FF, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1);
    run_op("eq_casg",  1'b1, 12'h5A5, 12'h5A5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 4);
    run_op("eq_case",  1'b1, 12'h5A5, 12'h5A5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4);
    run_op("const_gt", 1'b0, 12'h800, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 4);

    // START while busy must be dropped.
    @(negedge clk);
    early_sel = 1'b0;
    set_ops(12'h100, 12'h200, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    exp_q.push_back(3'b001);
    lat_q.push_back(4);
    accept_edge();
    start = 1'b0;
    step();
    set_ops(12'hFFF, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", 1'b1);
    check("ign_idle", 32'(st_m), 32'd0);

    // START held high: second accept on the DONE cycle.
    @(negedge clk);
    early_sel = 1'b1;
    set_ops(12'h800, 12'h7FF, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    exp_q.push_back(3'b100);
    lat_q.push_back(1);
    accept_edge();
    wait_done("held1", 1'b0);
    set_ops(12'h123, 12'h124, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(3'b001);
    lat_q.push_back(4);
    accept_edge();
    start = 1'b0;
    check("held2_busy0", 32'(busy_m), 32'd1);
    wait_done("held2", 1'b1);

    // Reset in the middle of a constant-time operation.
    @(negedge clk);
    early_sel = 1'b0;
    set_ops(12'hFFF, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    accept_edge();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst", 32'({busy_c, done_c, gt_c, eq_c, lt_c, st_c}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_nodone", 32'(done_m), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 1'b0, 12'h001, 12'h002, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 4);

    // Random operands differing in a chosen slice, both builds, both signedness.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rg, re, rl, rsel;
      logic [2:0] f;
      int lat, c;
      ra = W'($urandom_range(0, 4095));
      rb = ra ^ W'($urandom_range(0, 7) << (S * $urandom_range(0, NS - 1)));
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 4095));
      rs = 1'($urandom_range(0, 1));
      rsel = 1'(i % 2);
      c = $urandom_range(0, 2);
      rg = (c == 0); re = (c == 1); rl = (c == 2);
      model(ra, rb, rs, rg, re, rl, rsel, f, lat);
      run_op("rnd", rsel, ra, rb, rs, rg, re, rl, f, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
